fixpoint_vector_sweeper: RTL

- Sequential stimulus/response engine wrapped around a combinational fixpoint-check circuit: N_IN free inputs, one verdict output (1 = property holds).
- Enumerates every input assignment 0..2^N_IN-1 onto the checker inputs and samples the checker verdict each cycle.
- Counts failing assignments and captures the first counterexample.
- Reports pass/fail to the downstream controller through a valid/ready result handshake.

---
 rtl/fixpoint_vector_sweeper_pkg.sv | 22 ++
 rtl/fixpoint_vector_sweeper_fail_tracker.sv | 40 ++++
 rtl/fixpoint_vector_sweeper.sv | 109 ++++++++++
 3 files changed

// File: rtl/fixpoint_vector_sweeper_pkg.sv
// Shared types and default sizes for the fixpoint vector sweeper.
package fixpoint_sweep_pkg;

    localparam int N_IN_DEF  = 19;
    localparam int CNT_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        REPORT
    } sweep_state_e;

    // Result bundle laid out for the default configuration.
    typedef struct packed {
        logic                 pass;
        logic                 complete;
        logic [CNT_W_DEF-1:0] fail_cnt;
        logic [N_IN_DEF-1:0]  cex;
        logic                 cex_valid;
    } sweep_result_t;

endpackage

// File: rtl/fixpoint_vector_sweeper_fail_tracker.sv
// Saturating failure counter plus first-counterexample capture.
module sweep_fail_tracker
    import fixpoint_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample,
    input  logic             verdict,
    input  logic [N_IN-1:0]  vec,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [N_IN-1:0]  cex,
    output logic             cex_valid
);

    // Count failing samples (stopping at all-ones) and latch the first failing vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt  <= '0;
            cex       <= '0;
            cex_valid <= 1'b0;
        end else if (clear) begin
            fail_cnt  <= '0;
            cex       <= '0;
            cex_valid <= 1'b0;
        end else if (sample && !verdict) begin
            if (fail_cnt != {CNT_W{1'b1}}) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            if (!cex_valid) begin
                cex       <= vec;
                cex_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixpoint_vector_sweeper.sv
// Exhaustive stimulus engine for a combinational fixpoint checker.
// Optional macro SWEEP_EARLY_STOP_EN: stop at the first failing vector.
module fixpoint_vector_sweeper
    import fixpoint_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [N_IN-1:0]  vec_o,
    output logic             vec_valid_o,
    input  logic             verdict_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             pass_o,
    output logic             complete_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [N_IN-1:0]  cex_o,
    output logic             cex_valid_o
);

    sweep_state_e state;
    logic         last_vec;
    logic         tracker_clear;
    logic         no_fail_yet;

    // The terminal vector is all-ones, so an N_IN-wide AND-reduce marks it.
    assign last_vec      = &vec_o;
    assign tracker_clear = (state == IDLE) && start_i;
    assign no_fail_yet   = (fail_cnt_o == '0);

    sweep_fail_tracker #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tracker_clear),
        .sample    (vec_valid_o),
        .verdict   (verdict_i),
        .vec       (vec_o),
        .fail_cnt  (fail_cnt_o),
        .cex       (cex_o),
        .cex_valid (cex_valid_o)
    );

    // Sweep controller: walk every vector, then hold the result until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            vec_o       <= '0;
            vec_valid_o <= 1'b0;
            res_valid_o <= 1'b0;
            pass_o      <= 1'b0;
            complete_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state       <= SWEEP;
                        vec_o       <= '0;
                        vec_valid_o <= 1'b1;
                        pass_o      <= 1'b0;
                        complete_o  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (last_vec) begin
                        // Completion wins over a coincident abort.
                        state       <= REPORT;
                        vec_valid_o <= 1'b0;
                        res_valid_o <= 1'b1;
                        complete_o  <= 1'b1;
                        pass_o      <= no_fail_yet && verdict_i;
`ifdef SWEEP_EARLY_STOP_EN
                    end else if (!verdict_i) begin
                        state       <= REPORT;
                        vec_valid_o <= 1'b0;
                        res_valid_o <= 1'b1;
                        complete_o  <= 1'b0;
                        pass_o      <= 1'b0;
`endif
                    end else if (abort_i) begin
                        state       <= REPORT;
                        vec_valid_o <= 1'b0;
                        res_valid_o <= 1'b1;
                        complete_o  <= 1'b0;
                        pass_o      <= 1'b0;
                    end else begin
                        vec_o <= vec_o + N_IN'(1);
                    end
                end
                REPORT: begin
                    if (res_ready_i) begin
                        state       <= IDLE;
                        res_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
